// File: rtl/mem_pkg.sv
// Shared types and helpers for the M-stage memory access block:
// access-size encoding, FSM states, store strobe and alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: store_strobe = 4'b0001 << offset;
      SZ_HALF: store_strobe = 4'b0011 << offset;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the load lane from a 32-bit cache word and sign/zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane extraction followed by extension according to size
  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// M-stage memory access: drives the data cache, stalls on wait states,
// raises a sticky bus error on timeout and loads the M/W pipeline register.
module memory_access
  import mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_m_i,
  input  logic        mem_read_m_i,
  input  logic        mem_write_m_i,
  input  logic        reg_write_m_i,
  input  logic [1:0]  size_m_i,
  input  logic        unsigned_m_i,
  input  logic [31:0] alu_out_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [4:0]  write_reg_m_i,
  output logic        dc_req_o,
  output logic        dc_we_o,
  output logic [31:0] dc_addr_o,
  output logic [31:0] dc_wdata_o,
  output logic [3:0]  dc_wstrb_o,
  input  logic        dc_ready_i,
  input  logic [31:0] dc_rdata_i,
  output logic        stall_m_o,
  output logic        addr_err_m_o,
  output logic        bus_err_o,
  output logic        mem_to_reg_w_o,
  output logic        reg_write_w_o,
  output logic [4:0]  write_reg_w_o,
  output logic [31:0] alu_out_w_o,
  output logic [31:0] read_data_w_o
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_e      state;
  state_e      state_nx;
  logic [7:0]  wait_cnt;
  logic        mem_op;
  logic        misalign;
  logic        access;
  logic        completing;
  logic        timing_out;
  logic [31:0] load_data;

  load_align u_load_align (
    .rdata       (dc_rdata_i),
    .offset      (alu_out_m_i[1:0]),
    .size        (size_m_i),
    .is_unsigned (unsigned_m_i),
    .data        (load_data)
  );

  // Access classification, completion and timeout detection
  always_comb begin
    mem_op     = valid_m_i & (mem_read_m_i | mem_write_m_i);
    misalign   = mem_op & is_misaligned(size_m_i, alu_out_m_i[1:0]);
    access     = mem_op & ~misalign;
    timing_out = (state == ST_WAIT) & ~dc_ready_i & (wait_cnt == LIMIT);
    completing = (((state == ST_IDLE) & access) | (state == ST_WAIT)) & dc_ready_i;
  end

  // Cache request fields come straight from the M inputs, which the stall holds stable
  always_comb begin
    addr_err_m_o = misalign;
    dc_we_o      = mem_write_m_i;
    dc_addr_o    = {alu_out_m_i[31:2], 2'b00};
    dc_wstrb_o   = store_strobe(size_m_i, alu_out_m_i[1:0]);
    case (size_m_i)
      SZ_BYTE: dc_wdata_o = {4{write_data_m_i[7:0]}};
      SZ_HALF: dc_wdata_o = {2{write_data_m_i[15:0]}};
      default: dc_wdata_o = write_data_m_i;
    endcase
  end

  // Next-state, request and stall; all held low while reset is asserted
  always_comb begin
    state_nx  = state;
    dc_req_o  = 1'b0;
    stall_m_o = 1'b0;
    if (!rst_i) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          dc_req_o = access;
          if (access && !dc_ready_i) begin
            state_nx  = ST_WAIT;
            stall_m_o = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_WAIT: begin
          dc_req_o = ~timing_out;
          if (dc_ready_i || timing_out) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx  = ST_WAIT;
            stall_m_o = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State, wait counter, sticky bus error and the M/W pipeline register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= ST_IDLE;
      wait_cnt       <= 8'd0;
      bus_err_o      <= 1'b0;
      mem_to_reg_w_o <= 1'b0;
      reg_write_w_o  <= 1'b0;
      write_reg_w_o  <= 5'd0;
      alu_out_w_o    <= 32'd0;
      read_data_w_o  <= 32'd0;
    end else begin
      state <= state_nx;
      // Counts the WAIT cycles that end without ready; the timeout cycle sees LIMIT
      if (state == ST_WAIT && !dc_ready_i && !timing_out) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (timing_out) begin
        bus_err_o <= 1'b1;
      end
      if (!stall_m_o) begin
        mem_to_reg_w_o <= valid_m_i & mem_read_m_i;
        reg_write_w_o  <= reg_write_m_i & valid_m_i & ~misalign & ~timing_out;
        write_reg_w_o  <= write_reg_m_i;
        alu_out_w_o    <= alu_out_m_i;
        if (completing && mem_read_m_i) begin
          read_data_w_o <= load_data;
        end
      end else begin
        reg_write_w_o <= 1'b0;
      end
    end
  end

endmodule
